// File: rtl/easy_sdram_stub_pkg.sv
// Shared types for the EasySDRAM command-interface stub: FSM states, queued
// command layout and row-address helpers.
package easy_sdram_stub_pkg;
    localparam int ADDR_W  = 25;
    localparam int ROW_LSB = 10;
    localparam int ROW_W   = ADDR_W - ROW_LSB;

    typedef enum logic [1:0] {IDLE, ACTIVATE, REFRESH} stub_state_t;

    typedef struct packed {
        logic              isWrite;
        logic [ADDR_W-1:0] address;
        logic [1:0]        writeMask;
        logic [15:0]       writeData;
    } stub_cmd_t;

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:ROW_LSB];
    endfunction
endpackage

// File: rtl/stub_cmd_fifo.sv
// Command FIFO for the SDRAM stub. `full` is registered, so a push into a full
// FIFO is refused even when a pop happens in the same cycle.
module stub_cmd_fifo
    import easy_sdram_stub_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  stub_cmd_t                  din_i,
    output stub_cmd_t                  dout_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] usage_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int UW = $clog2(DEPTH + 1);

    stub_cmd_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [UW-1:0]   usage_q, usage_d;
    logic            full_q;
    logic            do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & (usage_q != '0);

    always_comb begin
        usage_d = usage_q;
        if (do_push && !do_pop)      usage_d = usage_q + UW'(1);
        else if (!do_push && do_pop) usage_d = usage_q - UW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            usage_q <= usage_d;
            full_q  <= (usage_d == UW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (usage_q == '0);
    assign full_o  = full_q;
    assign usage_o = usage_q;
endmodule

// File: rtl/easy_sdram_stub.sv
// Drop-in responder for the EasySDRAM user interface: serves commands from
// byte-lane block RAM while mimicking row-activate and refresh stalls.
module easy_sdram_stub
    import easy_sdram_stub_pkg::*;
#(
    parameter int FIFO_DEPTH       = 8,
    parameter int MEM_ADDR_BITS    = 10,
    parameter int READ_LATENCY     = 3,
    parameter int ACT_CYCLES       = 4,
    parameter int REFRESH_INTERVAL = 780,
    parameter int REFRESH_CYCLES   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            write,
    input  logic                            isWrite,
    input  logic [24:0]                     address,
    input  logic [1:0]                      writeMask,
    input  logic [15:0]                     writeData,
    input  logic                            keepOpen,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifoUsage,
    output logic                            readValid,
    output logic [24:0]                     raddr,
    output logic [15:0]                     rdata,
    output logic                            busy,
    output logic                            rowOpen,
    output logic [9:0]                      refreshCountdown
);
    localparam int MEM_WORDS = 2 ** MEM_ADDR_BITS;

    stub_cmd_t   push_cmd, head;
    logic        fifo_empty, pop, exec, hit, rd_fire;
    stub_state_t state_q, state_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic        row_open_q, row_open_d;
    logic [9:0]  cnt_q, cnt_d;

    assign push_cmd = '{isWrite, address, writeMask, writeData};

    stub_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (write),
        .pop_i   (pop),
        .din_i   (push_cmd),
        .dout_o  (head),
        .empty_o (fifo_empty),
        .full_o  (full),
        .usage_o (fifoUsage)
    );

    assign hit = row_open_q && (row_of(head.address) == row_q);

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        row_d      = row_q;
        row_open_d = row_open_q;
        pop        = 1'b0;
        exec       = 1'b0;
        cnt_d      = (cnt_q != '0) ? cnt_q - 10'd1 : '0;
        case (state_q)
            IDLE: begin
                if (cnt_q == '0) begin
                    state_d    = REFRESH;
                    tmr_d      = 8'(REFRESH_CYCLES - 1);
                    row_open_d = 1'b0;
                    cnt_d      = 10'(REFRESH_INTERVAL - 1);
                end else if (!fifo_empty && hit) begin
                    pop        = 1'b1;
                    exec       = 1'b1;
                    row_open_d = keepOpen;
                end else if (!fifo_empty) begin
                    // Miss closes the old row; the new one opens when ACTIVATE ends.
                    state_d    = ACTIVATE;
                    tmr_d      = 8'(ACT_CYCLES - 1);
                    row_d      = row_of(head.address);
                    row_open_d = 1'b0;
                end
            end
            ACTIVATE: begin
                if (tmr_q == '0) begin
                    pop        = 1'b1;
                    exec       = 1'b1;
                    row_open_d = keepOpen;
                    state_d    = IDLE;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            REFRESH: begin
                if (tmr_q == '0) state_d = IDLE;
                else             tmr_d   = tmr_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            row_q      <= '0;
            row_open_q <= 1'b0;
            cnt_q      <= 10'(REFRESH_INTERVAL - 1);
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            row_q      <= row_d;
            row_open_q <= row_open_d;
            cnt_q      <= cnt_d;
        end
    end

    // Backing store split into byte lanes so byte-enable BRAM is inferred.
    logic [7:0]  mem_lo [MEM_WORDS];
    logic [7:0]  mem_hi [MEM_WORDS];
    logic [15:0] ram_q, rd_data;
    logic [MEM_ADDR_BITS-1:0] idx;

    assign idx     = head.address[MEM_ADDR_BITS-1:0];
    assign rd_fire = exec & ~head.isWrite;

    always_ff @(posedge clk) begin
        if (exec && head.isWrite) begin
            if (head.writeMask[0]) mem_lo[idx] <= head.writeData[7:0];
            if (head.writeMask[1]) mem_hi[idx] <= head.writeData[15:8];
        end
        if (rd_fire) ram_q <= {mem_hi[idx], mem_lo[idx]};
    end

    logic [READ_LATENCY-1:0]       vld_pipe_q;
    logic [READ_LATENCY-1:0][24:0] addr_pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= rd_fire;
            if (rd_fire) addr_pipe_q[0] <= head.address;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_pipe_q[k]  <= vld_pipe_q[k-1];
                addr_pipe_q[k] <= addr_pipe_q[k-1];
            end
        end
    end

    // RAM output register is the first latency stage; the rest delay the data.
    if (READ_LATENCY == 1) begin : g_dat_direct
        assign rd_data = ram_q;
    end else begin : g_dat_pipe
        logic [READ_LATENCY-2:0][15:0] dat_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dat_q <= '0;
            end else begin
                dat_q[0] <= ram_q;
                for (int k = 1; k < READ_LATENCY - 1; k++) dat_q[k] <= dat_q[k-1];
            end
        end
        assign rd_data = dat_q[READ_LATENCY-2];
    end

    assign readValid        = vld_pipe_q[READ_LATENCY-1];
    assign raddr            = addr_pipe_q[READ_LATENCY-1];
    assign rdata            = readValid ? rd_data : '0;
    assign busy             = (state_q != IDLE);
    assign rowOpen          = row_open_q;
    assign refreshCountdown = cnt_q;
endmodule
